div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 16 +
 rtl/div_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_pkg.sv
// Shared state encoding and handshake constants for the sequential divider.
package div_seq_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;

   localparam logic DIV_START     = 1'b1;
   localparam logic DIV_STOP      = 1'b0;
   localparam logic DIV_READY     = 1'b1;
   localparam logic DIV_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned, HI/LO result.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DW = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            signed_div_i,
   input  logic [DW-1:0]   opdata1_i,
   input  logic [DW-1:0]   opdata2_i,
   input  logic            start_i,
   input  logic            annul_i,
   output logic [2*DW-1:0] result_o,
   output logic            ready_o
);

   localparam int CNT_W = $clog2(DW) + 1;

   function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic is_signed);
      logic signed [DW-1:0] sv;
      sv = v;
      if (is_signed && sv < 0)
         sv = -sv;
      return sv;
   endfunction

   function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] v, input logic neg);
      logic signed [DW-1:0] sv;
      sv = v;
      if (neg)
         sv = -sv;
      return sv;
   endfunction

   div_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [DW-1:0]    rem, rem_n;
   logic [DW-1:0]    quo, quo_n;
   logic [DW-1:0]    dvs, dvs_n;
   logic             neg_q, neg_q_n;
   logic             neg_r, neg_r_n;
   logic             ready_n;
   logic [2*DW-1:0]  result_n;

   logic [DW-1:0]    mag1, mag2;
   logic             neg1, neg2;
   logic [DW:0]      shifted;
   logic [DW:0]      trial;

   assign neg1 = signed_div_i & opdata1_i[DW-1];
   assign neg2 = signed_div_i & opdata2_i[DW-1];
   assign mag1 = magnitude(opdata1_i, signed_div_i);
   assign mag2 = magnitude(opdata2_i, signed_div_i);

   // The partial remainder stays below the divisor, so bit DW of the
   // 33-bit trial difference is set exactly when the subtraction went negative.
   assign shifted = {rem, quo[DW-1]};
   assign trial   = shifted - {1'b0, dvs};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ready_o  <= DIV_NOT_READY;
         result_o <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         rem      <= rem_n;
         quo      <= quo_n;
         dvs      <= dvs_n;
         neg_q    <= neg_q_n;
         neg_r    <= neg_r_n;
         ready_o  <= ready_n;
         result_o <= result_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rem_n    = rem;
      quo_n    = quo;
      dvs_n    = dvs;
      neg_q_n  = neg_q;
      neg_r_n  = neg_r;
      ready_n  = ready_o;
      result_n = result_o;

      case (state)
         DIV_FREE: begin
            ready_n  = DIV_NOT_READY;
            result_n = '0;
            if (start_i == DIV_START && !annul_i) begin
               cnt_n   = '0;
               dvs_n   = mag2;
               neg_q_n = neg1 ^ neg2;
               neg_r_n = neg1;
               rem_n   = '0;
               quo_n   = mag1;
               if (opdata2_i == '0) begin
                  quo_n   = '0;
                  state_n = DIV_BYZERO;
               end
`ifdef DIV_EARLY_OUT_EN
               else if (mag1 < mag2) begin
                  // Quotient is zero and the remainder is the raw dividend;
                  // BYZERO publishes {rem, quo} one cycle later.
                  rem_n   = opdata1_i;
                  quo_n   = '0;
                  state_n = DIV_BYZERO;
               end
`endif
               else begin
                  state_n = DIV_ON;
               end
            end
         end

         DIV_BYZERO: begin
            if (annul_i) begin
               state_n = DIV_FREE;
            end else begin
               state_n  = DIV_END;
               ready_n  = DIV_READY;
               result_n = {rem, quo};
            end
         end

         DIV_ON: begin
            if (annul_i) begin
               state_n = DIV_FREE;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(DW)) begin
               state_n  = DIV_END;
               ready_n  = DIV_READY;
               result_n = {apply_sign(rem, neg_r), apply_sign(quo, neg_q)};
               cnt_n    = '0;
            end else begin
               rem_n = trial[DW] ? shifted[DW-1:0] : trial[DW-1:0];
               quo_n = {quo[DW-2:0], ~trial[DW]};
               cnt_n = cnt + CNT_W'(1);
            end
         end

         DIV_END: begin
            if (start_i == DIV_STOP || annul_i) begin
               state_n  = DIV_FREE;
               ready_n  = DIV_NOT_READY;
               result_n = '0;
            end
         end

         default: begin
            state_n  = DIV_FREE;
            ready_n  = DIV_NOT_READY;
            result_n = '0;
         end
      endcase
   end

endmodule
